// File: rtl/int_to_fp.sv
// int_to_fp: streaming signed fixed-point (Q.FRAC_BITS) to IEEE-754 single
// converter. Three registered stages (magnitude, normalize, round/pack)
// advance together under one enable driven by downstream backpressure.
module int_to_fp #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 0
) (
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_areset,
   output logic                    s00_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic                    s00_axis_tlast,
   input  logic                    s00_axis_tvalid,
   output logic                    m00_axis_tvalid,
   output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                    m00_axis_tlast,
   input  logic                    m00_axis_tready
);

   localparam int STAGES = 3;

   typedef struct packed {
      logic        sign;
      logic [31:0] mag;
      logic        last;
   } s1_t;

   typedef struct packed {
      logic        sign;
      logic        zero;
      logic [4:0]  lz;
      logic [30:0] norm;   // normalized magnitude below the implicit one
      logic        last;
   } s2_t;

   logic [STAGES:1] vld_pipe;
   logic            en;
   s1_t             s1_d, s1_q;
   s2_t             s2_d, s2_q;
   logic [31:0]     norm_full;
   logic [31:0]     res_d, res_q;
   logic            last_q;

   // Leading-zero count; the highest set bit wins. Zero input yields 0,
   // which is harmless because zero is flagged separately.
   function automatic logic [4:0] lzc(input logic [31:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 32; i++)
         if (v[i]) n = 5'(31 - i);
      return n;
   endfunction

   // Whole pipeline stalls only when the output word is held by the consumer.
   assign en              = !vld_pipe[STAGES] || m00_axis_tready;
   assign s00_axis_tready = en;

   // S1 input: sign and magnitude; -0x80000000 wraps back to 0x80000000,
   // which is the correct unsigned magnitude.
   always_comb begin
      s1_d      = '0;
      s1_d.sign = s00_axis_tdata[31];
      s1_d.mag  = s00_axis_tdata[31] ? (~s00_axis_tdata + 32'd1) : s00_axis_tdata;
      s1_d.last = s00_axis_tlast;
   end

   // S2 input: normalize so bit 31 is the leading one; a magnitude of zero is
   // the only case where bit 31 stays clear after the shift.
   always_comb begin
      s2_d      = '0;
      s2_d.lz   = lzc(s1_q.mag);
      norm_full = s1_q.mag << s2_d.lz;
      s2_d.zero = !norm_full[31];
      s2_d.norm = norm_full[30:0];
      s2_d.sign = s1_q.sign;
      s2_d.last = s1_q.last;
   end

   // S3 input: biased exponent, round-to-nearest-even, pack. The exponent
   // never drops below 65, so no denormal path exists.
   always_comb begin
      logic [8:0]  exp_base;
      logic [7:0]  exp_fin;
      logic [23:0] mant_rnd;
      logic        guard, sticky, rnd;
      exp_base = 9'd158 - {4'd0, s2_q.lz} - 9'(FRAC_BITS);
      guard    = s2_q.norm[7];
      sticky   = |s2_q.norm[6:0];
      rnd      = guard && (sticky || s2_q.norm[8]);
      mant_rnd = {1'b0, s2_q.norm[30:8]} + {23'd0, rnd};
      exp_fin  = exp_base[7:0] + {7'd0, mant_rnd[23]};
      res_d    = s2_q.zero ? 32'd0 : {s2_q.sign, exp_fin, mant_rnd[22:0]};
   end

   // Valid shift register: bubbles enter as cleared bits and travel with data.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset)
         vld_pipe <= '0;
      else if (en)
         vld_pipe <= {vld_pipe[STAGES-1:1], s00_axis_tvalid};
   end

   // Stage data registers; all hold together while stalled.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         s1_q   <= '0;
         s2_q   <= '0;
         res_q  <= '0;
         last_q <= 1'b0;
      end else if (en) begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         res_q  <= res_d;
         last_q <= s2_q.last;
      end
   end

   assign m00_axis_tvalid = vld_pipe[STAGES];
   assign m00_axis_tdata  = res_q;
   assign m00_axis_tlast  = last_q;
   assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_int_to_fp.sv
// Directed bench for int_to_fp: vector table (FRAC_BITS 0 and 16 instances),
// backpressure stream, and reset mid-stream.
module tb_int_to_fp;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_tvalid, s_tlast, m_tready;
   logic [31:0] s_tdata;
   logic        s_tready0, s_tready16;
   logic        m_tvalid0, m_tvalid16, m_tlast0, m_tlast16;
   logic [31:0] m_tdata0, m_tdata16;
   logic [3:0]  m_tstrb0, m_tstrb16;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   int_to_fp #(.DATA_WIDTH(32), .FRAC_BITS(0)) dut0 (
      .s00_axi_aclk(clk), .s00_axi_areset(rst),
      .s00_axis_tready(s_tready0), .s00_axis_tdata(s_tdata),
      .s00_axis_tlast(s_tlast), .s00_axis_tvalid(s_tvalid),
      .m00_axis_tvalid(m_tvalid0), .m00_axis_tdata(m_tdata0),
      .m00_axis_tstrb(m_tstrb0), .m00_axis_tlast(m_tlast0),
      .m00_axis_tready(m_tready)
   );

   int_to_fp #(.DATA_WIDTH(32), .FRAC_BITS(16)) dut16 (
      .s00_axi_aclk(clk), .s00_axi_areset(rst),
      .s00_axis_tready(s_tready16), .s00_axis_tdata(s_tdata),
      .s00_axis_tlast(s_tlast), .s00_axis_tvalid(s_tvalid),
      .m00_axis_tvalid(m_tvalid16), .m00_axis_tdata(m_tdata16),
      .m00_axis_tstrb(m_tstrb16), .m00_axis_tlast(m_tlast16),
      .m00_axis_tready(m_tready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] din;
      logic        last;
      bit          f16;
      logic [31:0] exp;
   } vec_t;

   // Send one word with the consumer ready, then check latency, data, tlast.
   task automatic send_check(input string name, input logic [31:0] d, input logic l,
                             input bit f16, input logic [31:0] exp);
      int lat;
      @(posedge clk); #1;
      s_tdata = d; s_tlast = l; s_tvalid = 1'b1; m_tready = 1'b1;
      @(negedge clk);
      chk({name, "_tready"}, {31'd0, f16 ? s_tready16 : s_tready0}, 32'd1);
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
      lat = 1;
      while (!(f16 ? m_tvalid16 : m_tvalid0) && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'd3);
      chk({name, "_data"}, f16 ? m_tdata16 : m_tdata0, exp);
      chk({name, "_last"}, {31'd0, f16 ? m_tlast16 : m_tlast0}, {31'd0, l});
   endtask

   vec_t        vecs[13];
   logic [31:0] bp_in[8];
   logic [31:0] bp_exp[8];
   logic [3:0]  bp_pat;

   initial begin
      int          in_idx, out_idx;
      bit          have_held;
      logic [31:0] held;
      logic        held_last;

      vecs[0]  = '{32'h00000001, 1'b0, 1'b0, 32'h3F800000};
      vecs[1]  = '{32'hFFFFFFFF, 1'b0, 1'b0, 32'hBF800000};
      vecs[2]  = '{32'h00000000, 1'b0, 1'b0, 32'h00000000};
      vecs[3]  = '{32'h80000000, 1'b0, 1'b0, 32'hCF000000};
      vecs[4]  = '{32'h7FFFFFFF, 1'b1, 1'b0, 32'h4F000000};
      vecs[5]  = '{32'h01000001, 1'b0, 1'b0, 32'h4B800000};
      vecs[6]  = '{32'h01000003, 1'b0, 1'b0, 32'h4B800002};
      vecs[7]  = '{32'h01000002, 1'b1, 1'b0, 32'h4B800001};
      vecs[8]  = '{32'h00000003, 1'b0, 1'b0, 32'h40400000};
      vecs[9]  = '{32'hFFFFFFFD, 1'b0, 1'b0, 32'hC0400000};
      vecs[10] = '{32'h00018000, 1'b0, 1'b1, 32'h3FC00000};
      vecs[11] = '{32'hFFFF0000, 1'b1, 1'b1, 32'hBF800000};
      vecs[12] = '{32'h00000000, 1'b0, 1'b1, 32'h00000000};

      for (int i = 0; i < 8; i++) bp_in[i] = 32'(i + 1);
      bp_exp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
      bp_pat = 4'b1001;   // per-cycle ready: 1,0,0,1

      // Reset state
      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 32'd0; m_tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", {31'd0, m_tvalid0}, 32'd0);
      chk("rst_tdata", m_tdata0, 32'd0);
      chk("rst_tlast", {31'd0, m_tlast0}, 32'd0);
      chk("tstrb", {28'd0, m_tstrb0}, 32'hF);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_tready", {31'd0, s_tready0}, 32'd1);

      // Vector table
      for (int i = 0; i < 13; i++)
         send_check($sformatf("vec%0d", i), vecs[i].din, vecs[i].last, vecs[i].f16, vecs[i].exp);

      // Backpressure stream of 8 words, tlast on the 8th
      in_idx = 0; out_idx = 0; have_held = 0; held = '0; held_last = 1'b0;
      for (int cyc = 0; cyc < 200 && out_idx < 8; cyc++) begin
         @(posedge clk); #1;
         m_tready = bp_pat[cyc % 4];
         s_tvalid = (in_idx < 8);
         s_tdata  = (in_idx < 8) ? bp_in[in_idx] : 32'd0;
         s_tlast  = (in_idx == 7);
         @(negedge clk);
         chk("bp_tready", {31'd0, s_tready0}, {31'd0, !(m_tvalid0 && !m_tready)});
         if (have_held) begin
            chk("bp_hold_valid", {31'd0, m_tvalid0}, 32'd1);
            chk("bp_hold_data", m_tdata0, held);
            chk("bp_hold_last", {31'd0, m_tlast0}, {31'd0, held_last});
         end
         if (m_tvalid0 && m_tready) begin
            chk($sformatf("bp_data%0d", out_idx), m_tdata0, bp_exp[out_idx]);
            chk($sformatf("bp_last%0d", out_idx), {31'd0, m_tlast0}, {31'd0, out_idx == 7});
            out_idx++;
         end
         have_held = m_tvalid0 && !m_tready;
         held      = m_tdata0;
         held_last = m_tlast0;
         if (s_tvalid && s_tready0) in_idx++;
      end
      chk("bp_count", 32'(out_idx), 32'd8);
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
      repeat (4) @(posedge clk);

      // Reset mid-stream: three words stalled in the pipe, then discarded
      #1;
      m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 32'd5; s_tlast = 1'b0;
      @(posedge clk); #1; s_tdata = 32'd6;
      @(posedge clk); #1; s_tdata = 32'd7; s_tlast = 1'b1;
      @(posedge clk); #1; s_tvalid = 1'b0; s_tlast = 1'b0;
      chk("mid_full_valid", {31'd0, m_tvalid0}, 32'd1);
      chk("mid_full_data", m_tdata0, 32'h40A00000);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_valid", {31'd0, m_tvalid0}, 32'd0);
      chk("mid_rst_data", m_tdata0, 32'd0);
      chk("mid_rst_last", {31'd0, m_tlast0}, 32'd0);
      rst = 1'b0; m_tready = 1'b1;
      chk("mid_rst_tready", {31'd0, s_tready0}, 32'd1);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk($sformatf("mid_quiet%0d", k), {31'd0, m_tvalid0}, 32'd0);
      end
      send_check("after_rst", 32'd2, 1'b1, 1'b0, 32'h40000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
